// File: rtl/mixer_tdm.sv
// Time-multiplexed N-channel mixer: snapshots all voices on a sample_clock rising
// edge, accumulates one gained/muted channel per clk, then rescales and saturates.
module mixer_tdm #(
  parameter int BITDEPTH = 14,
  parameter int CHANNELS = 8,
  parameter int GAINBITS = 4,
  parameter int MIXSHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_clock,
  input  logic [CHANNELS*BITDEPTH-1:0] in,
  input  logic [CHANNELS*GAINBITS-1:0] gain,
  input  logic [CHANNELS-1:0]          mute,
  output logic [BITDEPTH-1:0]          mix,
  output logic                         mix_valid,
  output logic                         clip,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W  = BITDEPTH + GAINBITS + $clog2(CHANNELS) + 1;
  localparam int PROD_W = BITDEPTH + GAINBITS + 1;
  localparam int SHIFT  = GAINBITS - 1 + MIXSHIFT;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (BITDEPTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t                   state_q;
  logic                     sc_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CH_W-1:0]          ch_q;
  logic [BITDEPTH-1:0]      mix_q;
  logic                     mix_valid_q;
  logic                     clip_q;
  logic                     busy_q;
  logic                     overrun_q;

  logic [BITDEPTH-1:0]      snap_in_q   [CHANNELS];
  logic [GAINBITS-1:0]      snap_gain_q [CHANNELS];
  logic [CHANNELS-1:0]      snap_mute_q;

  logic                     start_d;
  logic signed [BITDEPTH-1:0] samp_d;
  logic signed [PROD_W-1:0] term_d;
  logic signed [ACC_W-1:0]  scaled_d;
  logic [BITDEPTH:0]        sat_d;

  // Returns {clip, value} with value clamped to the signed BITDEPTH range.
  function automatic logic [BITDEPTH:0] saturate(input logic signed [ACC_W-1:0] r);
    logic [BITDEPTH:0] res;
    if (r > SAT_MAX) begin
      res = {1'b1, SAT_MAX[BITDEPTH-1:0]};
    end else if (r < SAT_MIN) begin
      res = {1'b1, SAT_MIN[BITDEPTH-1:0]};
    end else begin
      res = {1'b0, r[BITDEPTH-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    start_d  = sample_clock & ~sc_q;
    samp_d   = {~snap_in_q[ch_q][BITDEPTH-1], snap_in_q[ch_q][BITDEPTH-2:0]};
    term_d   = '0;
    if (!snap_mute_q[ch_q]) begin
      term_d = PROD_W'(samp_d) * PROD_W'($signed({1'b0, snap_gain_q[ch_q]}));
    end
    scaled_d = acc_q >>> SHIFT;
    sat_d    = saturate(scaled_d);
  end

  // Snapshot: data-only registers, loaded once per pass so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start_d) begin
      for (int i = 0; i < CHANNELS; i++) begin
        snap_in_q[i]   <= in[i*BITDEPTH +: BITDEPTH];
        snap_gain_q[i] <= gain[i*GAINBITS +: GAINBITS];
      end
      snap_mute_q <= mute;
    end
  end

  // sc_q resets high so a sample_clock already high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sc_q        <= 1'b1;
      acc_q       <= '0;
      ch_q        <= '0;
      mix_q       <= {1'b1, {(BITDEPTH-1){1'b0}}};
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sc_q        <= sample_clock;
      mix_valid_q <= 1'b0;
      overrun_q   <= start_d & (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (start_d) begin
            acc_q   <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_q + ACC_W'(term_d);
          ch_q  <= ch_q + CH_W'(1);
          if (ch_q == CH_W'(CHANNELS - 1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          mix_q       <= {~sat_d[BITDEPTH-1], sat_d[BITDEPTH-2:0]};
          clip_q      <= sat_d[BITDEPTH];
          mix_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mix       = mix_q;
  assign mix_valid = mix_valid_q;
  assign clip      = clip_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mixer_tdm.sv
// Bench for mixer_tdm: arithmetic reference model with per-cycle compare,
// directed literal cases and randomized passes.
module tb_mixer_tdm;
  localparam int BD = 14;
  localparam int CH = 8;
  localparam int GB = 4;
  localparam int MS = 3;
  localparam int MID = 8192;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sample_clock = 1'b0;
  logic [CH*BD-1:0]  in_v = '0;
  logic [CH*GB-1:0]  gain_v = '0;
  logic [CH-1:0]     mute_v = '0;
  logic [BD-1:0]     mix;
  logic              mix_valid, clip, busy, overrun;

  int checks = 0;
  int errors = 0;

  mixer_tdm #(.BITDEPTH(BD), .CHANNELS(CH), .GAINBITS(GB), .MIXSHIFT(MS)) dut (
    .clk(clk), .rst(rst), .sample_clock(sample_clock), .in(in_v), .gain(gain_v),
    .mute(mute_v), .mix(mix), .mix_valid(mix_valid), .clip(clip), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed sum of gained channels, floor-shifted, clamped, re-offset.
  function automatic void model_mix(input logic [CH*BD-1:0] iv, input logic [CH*GB-1:0] gv,
                                    input logic [CH-1:0] mv, output int mx, output int cl);
    int sum;
    int r;
    sum = 0;
    for (int c = 0; c < CH; c++)
      if (!mv[c]) sum += (int'(iv[c*BD +: BD]) - MID) * int'(gv[c*GB +: GB]);
    r  = sum >>> (GB - 1 + MS);
    cl = 0;
    if (r > MID - 1) begin r = MID - 1; cl = 1; end
    if (r < -MID)    begin r = -MID;    cl = 1; end
    mx = r + MID;
  endfunction

  int m_mix = MID, m_valid = 0, m_clip = 0, m_busy = 0, m_ov = 0;
  int m_rem = 0, p_mix = MID, p_clip = 0;
  bit m_sc = 1'b1;

  always @(posedge clk or negedge rst) begin
    bit st;
    if (!rst) begin
      m_sc = 1'b1; m_rem = 0; m_mix = MID; m_valid = 0; m_clip = 0; m_busy = 0; m_ov = 0;
    end else begin
      st = sample_clock && !m_sc;
      m_sc = sample_clock;
      m_valid = 0;
      m_ov = 0;
      if (m_rem == 0) begin
        if (st) begin
          model_mix(in_v, gain_v, mute_v, p_mix, p_clip);
          m_rem  = CH + 1;
          m_busy = 1;
        end
      end else begin
        m_ov = int'(st);
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_valid = 1; m_mix = p_mix; m_clip = p_clip;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("mix", int'(mix), m_mix);
    chk("mix_valid", int'(mix_valid), m_valid);
    chk("clip", int'(clip), m_clip);
    chk("busy", int'(busy), m_busy);
    chk("overrun", int'(overrun), m_ov);
  end

  task automatic set_all(input int iv, input int g, input logic [CH-1:0] m);
    for (int c = 0; c < CH; c++) begin
      in_v[c*BD +: BD]   = BD'(iv);
      gain_v[c*GB +: GB] = GB'(g);
    end
    mute_v = m;
  endtask

  // One pass: E0 is the posedge after the first negedge; lat counts edges from E0 to mix_valid.
  task automatic run_pass(input int chg_at, input int chg_val, input int ov_at,
                          output int lat, output int busy_n, output int ov_n, output int val_n);
    lat = -1; busy_n = 0; ov_n = 0; val_n = 0;
    @(negedge clk);
    sample_clock = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) sample_clock = 1'b0;
      if (i == ov_at) sample_clock = 1'b1;
      if (i == ov_at + 2) sample_clock = 1'b0;
      if (i == chg_at) in_v[7*BD +: BD] = BD'(chg_val);
      if (busy) busy_n++;
      if (overrun) ov_n++;
      if (mix_valid) begin
        val_n++;
        if (lat < 0) lat = i - 1;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL pass_timeout actual=none expected=mix_valid within 20 clks");
    end
  endtask

  initial begin
    int lat, bn, on, vn;
    set_all(MID, 8, '0);
    repeat (3) @(negedge clk);
    chk("reset_mix", int'(mix), 8192);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(mix_valid), 0);
    chk("reset_clip", int'(clip), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_pass(-1, 0, -1, lat, bn, on, vn);
    chk("silence_mix", int'(mix), 8192);
    chk("silence_clip", int'(clip), 0);
    chk("silence_latency", lat, 9);
    chk("silence_busy_clks", bn, 9);
    chk("silence_valid_count", vn, 1);

    in_v[0 +: BD] = 14'd8992;
    run_pass(-1, 0, -1, lat, bn, on, vn);
    chk("single_mix", int'(mix), 8292);
    chk("single_clip", int'(clip), 0);
    gain_v[0 +: GB] = 4'd0;
    run_pass(-1, 0, -1, lat, bn, on, vn);
    chk("gain0_mix", int'(mix), 8192);

    set_all(16383, 15, '0);
    run_pass(-1, 0, -1, lat, bn, on, vn);
    chk("satpos_mix", int'(mix), 16383);
    chk("satpos_clip", int'(clip), 1);
    set_all(0, 15, '0);
    run_pass(-1, 0, -1, lat, bn, on, vn);
    chk("satneg_mix", int'(mix), 0);
    chk("satneg_clip", int'(clip), 1);
    set_all(MID, 15, '0);
    run_pass(-1, 0, -1, lat, bn, on, vn);
    chk("unsat_clip", int'(clip), 0);
    chk("unsat_mix", int'(mix), 8192);

    set_all(16383, 15, 8'hFF);
    run_pass(-1, 0, -1, lat, bn, on, vn);
    chk("muted_mix", int'(mix), 8192);

    set_all(MID, 8, '0);
    in_v[7*BD +: BD] = 14'd8992;
    run_pass(3, 0, -1, lat, bn, on, vn);
    chk("snapshot_mix", int'(mix), 8292);

    set_all(MID, 8, '0);
    in_v[2*BD +: BD] = 14'd7392;
    run_pass(-1, 0, 3, lat, bn, on, vn);
    chk("overrun_pulses", on, 1);
    chk("overrun_valid_count", vn, 1);
    chk("overrun_latency", lat, 9);
    chk("overrun_mix", int'(mix), 8092);

    for (int n = 0; n < 24; n++) begin
      for (int c = 0; c < CH; c++) begin
        in_v[c*BD +: BD]   = BD'($urandom_range(0, 16383));
        gain_v[c*GB +: GB] = GB'($urandom_range(0, 15));
      end
      mute_v = CH'($urandom);
      if (n % 4 == 0) set_all((n % 8 == 0) ? 16383 : 0, 15, '0);
      run_pass(int'($urandom_range(1, 8)), int'($urandom_range(0, 16383)), -1, lat, bn, on, vn);
      chk("rand_latency", lat, 9);
    end

    set_all(MID, 8, '0);
    in_v[1*BD +: BD] = 14'd8992;
    run_pass(-1, 0, -1, lat, bn, on, vn);
    chk("prereset_mix", int'(mix), 8292);
    in_v[1*BD +: BD] = 14'd16000;
    @(negedge clk);
    sample_clock = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_mix", int'(mix), 8192);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_valid", int'(mix_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bn = 0; vn = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) bn++;
      if (mix_valid) vn++;
    end
    chk("held_high_busy", bn, 0);
    chk("held_high_valid", vn, 0);
    sample_clock = 1'b0;
    in_v[1*BD +: BD] = 14'd8992;
    run_pass(-1, 0, -1, lat, bn, on, vn);
    chk("postreset_latency", lat, 9);
    chk("postreset_mix", int'(mix), 8292);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mixer_tdm.md
# mixer_tdm

Parametrised, time-multiplexed N-channel audio mixer that generalises the fixed four-input mixer stage and the ad-hoc halving/summing of sub-mixes in the synth top level. It sits between the voices and the DAC. On each sample_clock rising edge, it captures every voice output, then applies per-channel gain and mute. It accumulates one channel per clk, rescales and saturates the result, and presents one offset-binary sample to the DAC.

## Interface
Parameters:
- BITDEPTH, 14, sample width; samples are offset-binary, silence = 2^(BITDEPTH-1)
- CHANNELS, 8, number of input channels (≥1)
- GAINBITS, 4, per-channel gain width; unity gain = 2^(GAINBITS-1)
- MIXSHIFT, 3, extra right shift applied to the sum (default = log2 CHANNELS)

Ports:
- clk  in  1  system clock (8 MHz)
- rst  in  1  reset, asynchronous, active-low
- sample_clock  in  1  sample-rate square wave, sampled in clk domain; rising edge starts a pass
- in  in  CHANNELS*BITDEPTH  channel i at [i*BITDEPTH +: BITDEPTH]
- gain  in  CHANNELS*GAINBITS  channel i at [i*GAINBITS +: GAINBITS], unsigned
- mute  in  CHANNELS  bit i = 1 forces channel i to contribute 0
- mix  out  BITDEPTH  mixed sample, offset-binary
- mix_valid  out  1  one-clk pulse when mix updates
- clip  out  1  registered with mix: 1 if that sample saturated
- busy  out  1  pass in progress
- overrun  out  1  one-clk pulse: sample_clock edge arrived while busy

## Operation
- Edge detect: sc_d <= sample_clock each clk. start = sample_clock & ~sc_d.
- FSM states: IDLE, ACCUM, FINISH.
- IDLE, start=1: snapshot in, gain and mute into internal registers. Clear acc and ch. Go to ACCUM. Set busy=1.
- ACCUM: s = snapshot[ch] with MSB inverted, as signed BITDEPTH. term = mute[ch] ? 0 : s * gain[ch], a signed product. acc += term. ch increments. After ch = CHANNELS-1, go to FINISH.
- FINISH: r = acc >>> (GAINBITS-1+MIXSHIFT), an arithmetic shift.
  - Saturate r to [-2^(BITDEPTH-1), 2^(BITDEPTH-1)-1]. clip <= (saturated).
  - mix <= saturated value with MSB inverted. mix_valid <= 1.
  - Go to IDLE. busy <= 0.
- acc width: BITDEPTH+GAINBITS+clog2(CHANNELS)+1 signed. Must never wrap for any input.
- Inputs are read only at snapshot. Changes during a pass do not affect that pass.
- start while busy: ignored, and overrun pulses for one clk. The current pass is unaffected.
- gain = 0 behaves identically to mute.
- Reset values, all outputs and state:
  - mix = 2^(BITDEPTH-1); mix_valid, clip, busy, overrun = 0
  - state = IDLE; acc, ch = 0
  - sc_d = 1, so a sample_clock held high through reset release does not start a pass.
- Reset asserted mid-pass: the pass is aborted immediately and no mix_valid is produced.

## Timing
- E0 = the clk edge at which start=1. Snapshot is taken at E0.
- Channel k is accumulated at edge E(k+1), for k = 0..CHANNELS-1.
- FINISH is active between E(CHANNELS) and E(CHANNELS+1).
- mix, clip and mix_valid update at E(CHANNELS+1). Latency is CHANNELS+1 clks from E0.
- mix_valid is high for exactly one clk. mix holds until the next FINISH.
- busy is high from E0 to E(CHANNELS+1).
- Minimum sample_clock period is CHANNELS+2 clks. The default period of 256 clks gives ample margin.
- overrun is registered: it is high for the clk after the edge that saw start while busy.

## Test plan
All cases use defaults (BITDEPTH=14, CHANNELS=8, GAINBITS=4, MIXSHIFT=3); the shift is 6.
- Silence: all in=8192, gain=8, mute=0, one sample_clock edge -> mix=8192, clip=0. mix_valid pulses exactly 9 clks after E0, busy high for 9 clks.
- Single channel: in[0]=8992, others 8192, gain[0]=8 -> 800*8=6400 >>>6 = 100 -> mix=8292, clip=0. Repeat with gain[0]=0 -> mix=8192.
- Saturation:
  - All in=16383, gain=15 -> 8191*15*8=982920 >>>6 = 15358 -> mix=16383, clip=1.
  - All in=0, gain=15 -> mix=0, clip=1.
  - Then all in=8192 -> clip=0 on the next mix_valid.
- Mute and snapshot: all in=16383, gain=15, mute=8'hFF -> mix=8192. Separately, change in[7] at E3 of a pass -> result reflects the E0 values.
- Overrun: drive a second sample_clock rising edge 3 clks after E0 -> overrun pulses for one clk. Only one mix_valid occurs, at E9, with the correct value.
- Reset: assert rst low between E4 and E5 -> mix=8192, busy=0, mix_valid=0 asynchronously. Release with sample_clock held high -> no pass starts. The next rising edge gives a normal pass.
